ir_packet_tx: RTL

Parametrised infrared packet transmitter for the remote-control-car link, sitting between the bus-interface command register and the IR LED pin. It sends one packet per request: carrier burst START, GAP, CAR_SELECT burst, GAP, then one burst plus GAP for each command bit. Carrier division and all burst and gap lengths are run-time inputs, so any car colour is selected without resynthesis. Unlike the fixed single-car transmitter, it latches its configuration and command per packet, phase-aligns the carrier to each burst, and reports BUSY/DONE with a one-deep pending request.

---
 rtl/ir_tx_pkg.sv | 39 +++
 rtl/ir_burst_timer.sv | 38 +++
 rtl/ir_packet_tx.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/ir_tx_pkg.sv
// Shared types and per-car defaults for the infrared packet transmitter.
// The transmitter itself is width-parametrised; the defaults below are plain integers.
package ir_tx_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_GAP,
        S_SELECT,
        S_BIT
    } tx_state_t;

    typedef struct packed {
        int unsigned div;
        int unsigned start_len;
        int unsigned select_len;
        int unsigned gap_len;
        int unsigned assert_len;
        int unsigned deassert_len;
    } car_cfg_t;

    // Yellow car at a 50 MHz system clock (40 kHz carrier).
    localparam car_cfg_t YELLOW_CFG = '{
        div:          1250,
        start_len:    88,
        select_len:   22,
        gap_len:      40,
        assert_len:   44,
        deassert_len: 22
    };

    localparam int MIN_DIV = 2;
    localparam int MIN_LEN = 1;

    function automatic logic is_burst(input tx_state_t s);
        return (s == S_START) || (s == S_SELECT) || (s == S_BIT);
    endfunction

endpackage

// File: rtl/ir_burst_timer.sv
// Carrier phase and period counters for one FSM state of the IR transmitter.
// Reports the carrier level and a strobe on the last cycle of the state.
module ir_burst_timer #(
    parameter int DIV_W = 12,
    parameter int LEN_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             restart,
    input  logic [DIV_W-1:0] div,
    input  logic [LEN_W-1:0] len,
    output logic             carrier,
    output logic             state_end
);

    logic [DIV_W-1:0] phase;
    logic [LEN_W-1:0] period;
    logic             phase_wrap;

    assign phase_wrap = (phase == div - DIV_W'(1));
    assign state_end  = phase_wrap && (period == len - LEN_W'(1));
    // First half of every carrier period is high, so each burst begins high.
    assign carrier    = (phase < (div >> 1));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST || restart) begin
            phase  <= '0;
            period <= '0;
        end else if (phase_wrap) begin
            phase  <= '0;
            period <= period + LEN_W'(1);
        end else begin
            phase  <= phase + DIV_W'(1);
        end
    end

endmodule

// File: rtl/ir_packet_tx.sv
// IR packet transmitter: START, SELECT and command-bit bursts separated by gaps,
// with per-packet captured configuration and a one-deep pending request.
module ir_packet_tx
    import ir_tx_pkg::*;
#(
    parameter int CMD_BITS = 4,
    parameter int DIV_W    = 12,
    parameter int LEN_W    = 8
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                SEND_PACKET,
    input  logic [CMD_BITS-1:0] COMMAND,
    input  logic [DIV_W-1:0]    CARRIER_DIV,
    input  logic [LEN_W-1:0]    START_LEN,
    input  logic [LEN_W-1:0]    SELECT_LEN,
    input  logic [LEN_W-1:0]    GAP_LEN,
    input  logic [LEN_W-1:0]    ASSERT_LEN,
    input  logic [LEN_W-1:0]    DEASSERT_LEN,
    output logic                BUSY,
    output logic                DONE,
    output logic                IR_LED
);

    localparam int IDX_W = (CMD_BITS > 1) ? $clog2(CMD_BITS) : 1;

    tx_state_t state, state_nxt;
    tx_state_t after_gap, after_gap_nxt;
    logic [IDX_W-1:0] bit_idx, bit_idx_nxt;

    logic [CMD_BITS-1:0] cmd_sh;
    logic [DIV_W-1:0]    div_sh;
    logic [LEN_W-1:0]    start_sh, select_sh, gap_sh, assert_sh, deassert_sh;
    logic                pending;

    logic             start_pkt;
    logic [LEN_W-1:0] cur_len;
    logic             restart, carrier, state_end;
    logic             led_nxt, done_nxt;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] v);
        return (v < LEN_W'(MIN_LEN)) ? LEN_W'(MIN_LEN) : v;
    endfunction

    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] v);
        return (v < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : v;
    endfunction

    assign start_pkt = (state == S_IDLE) && (SEND_PACKET || pending);
    assign BUSY      = (state != S_IDLE);

    ir_burst_timer #(
        .DIV_W (DIV_W),
        .LEN_W (LEN_W)
    ) u_timer (
        .CLK       (CLK),
        .RST       (RST),
        .restart   (restart),
        .div       (div_sh),
        .len       (cur_len),
        .carrier   (carrier),
        .state_end (state_end)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            after_gap <= S_IDLE;
            bit_idx   <= '0;
            IR_LED    <= 1'b0;
            DONE      <= 1'b0;
        end else begin
            state     <= state_nxt;
            after_gap <= after_gap_nxt;
            bit_idx   <= bit_idx_nxt;
            IR_LED    <= led_nxt;
            DONE      <= done_nxt;
        end
    end

    // NOTE: shadow registers are data-only and always loaded before use, so they carry no reset.
    always_ff @(posedge CLK) begin
        if (start_pkt) begin
            cmd_sh      <= COMMAND;
            div_sh      <= clamp_div(CARRIER_DIV);
            start_sh    <= clamp_len(START_LEN);
            select_sh   <= clamp_len(SELECT_LEN);
            gap_sh      <= clamp_len(GAP_LEN);
            assert_sh   <= clamp_len(ASSERT_LEN);
            deassert_sh <= clamp_len(DEASSERT_LEN);
        end
    end

    // Requests while idle start immediately, so only busy-time requests are remembered.
    always_ff @(posedge CLK) begin
        if (RST || state == S_IDLE) begin
            pending <= 1'b0;
        end else if (SEND_PACKET) begin
            pending <= 1'b1;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt     = state;
        after_gap_nxt = after_gap;
        bit_idx_nxt   = bit_idx;
        case (state)
            S_IDLE: begin
                if (start_pkt) state_nxt = S_START;
            end
            S_START: begin
                if (state_end) begin
                    state_nxt     = S_GAP;
                    after_gap_nxt = S_SELECT;
                end
            end
            S_SELECT: begin
                if (state_end) begin
                    state_nxt     = S_GAP;
                    after_gap_nxt = S_BIT;
                    bit_idx_nxt   = '0;
                end
            end
            S_BIT: begin
                if (state_end) begin
                    state_nxt = S_GAP;
                    if (bit_idx == IDX_W'(CMD_BITS - 1)) begin
                        after_gap_nxt = S_IDLE;
                    end else begin
                        after_gap_nxt = S_BIT;
                        bit_idx_nxt   = bit_idx + IDX_W'(1);
                    end
                end
            end
            S_GAP: begin
                if (state_end) state_nxt = after_gap;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Kept apart from the output process: the timer's end strobe depends on it.
    always_comb begin
        cur_len = gap_sh;
        case (state)
            S_START:  cur_len = start_sh;
            S_SELECT: cur_len = select_sh;
            S_BIT:    cur_len = cmd_sh[bit_idx] ? assert_sh : deassert_sh;
            default:  cur_len = gap_sh;
        endcase
    end

    always_comb begin
        restart  = (state == S_IDLE) || state_end;
        led_nxt  = is_burst(state) && carrier;
        done_nxt = (state == S_GAP) && (after_gap == S_IDLE) && state_end;
    end

endmodule
